// File: rtl/decode_stage_reg_pkg.sv
// Shared constants for the decode stage: default datapath width, MIPS-subset
// opcode/funct values and the ALU operation encodings driven towards EX.
package decode_stage_reg_pkg;

  localparam int WORD_DEF = 32;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] HALT_OP  = 6'h3f;

  // R-type funct codes (instr[5:0])
  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2a;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_SLT = 4'd4,
    ALU_SLL = 4'd5,
    ALU_SRL = 4'd6,
    ALU_NOP = 4'd15
  } alu_op_e;

endpackage

// File: rtl/decode_stage_reg_decode_ctrl.sv
// Combinational control decoder: opcode/funct to control flags, ALU op and
// operand-select strobes. Anything unrecognised (including halt) is a NOP.
module decode_ctrl
  import decode_stage_reg_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [3:0] alu_op,
  output logic       mem_r,
  output logic       mem_w,
  output logic       wb_en,
  output logic       branch,
  output logic       jump,
  output logic       is_halt,
  output logic       use_rs,
  output logic       use_rt,
  output logic       a_shamt,
  output logic       b_imm,
  output logic       rd_is_rd,
  output logic       rd_is_rt,
  output logic       st_rt
);

  // Opcode/funct decode; defaults describe a NOP so unknown encodings fall out safely
  always_comb begin
    alu_op   = ALU_NOP;
    mem_r    = 1'b0;
    mem_w    = 1'b0;
    wb_en    = 1'b0;
    branch   = 1'b0;
    jump     = 1'b0;
    is_halt  = 1'b0;
    use_rs   = 1'b0;
    use_rt   = 1'b0;
    a_shamt  = 1'b0;
    b_imm    = 1'b0;
    rd_is_rd = 1'b0;
    rd_is_rt = 1'b0;
    st_rt    = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: begin
            use_rs   = 1'b1;
            use_rt   = 1'b1;
            rd_is_rd = 1'b1;
            wb_en    = 1'b1;
            case (funct)
              FN_SUB:  alu_op = ALU_SUB;
              FN_AND:  alu_op = ALU_AND;
              FN_OR:   alu_op = ALU_OR;
              FN_SLT:  alu_op = ALU_SLT;
              default: alu_op = ALU_ADD;
            endcase
          end
          FN_SLL, FN_SRL: begin
            // Shift amount comes from the instruction, so rs is not a source
            use_rt   = 1'b1;
            a_shamt  = 1'b1;
            rd_is_rd = 1'b1;
            wb_en    = 1'b1;
            alu_op   = (funct == FN_SLL) ? ALU_SLL : ALU_SRL;
          end
          default: ;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW: begin
        // rt is the destination field here; for sw it carries the store data
        alu_op   = ALU_ADD;
        use_rs   = 1'b1;
        b_imm    = 1'b1;
        rd_is_rt = 1'b1;
        mem_r    = (opcode == OP_LW);
        mem_w    = (opcode == OP_SW);
        wb_en    = (opcode != OP_SW);
        st_rt    = (opcode == OP_SW);
      end
      OP_BEQ: begin
        alu_op = ALU_SUB;
        branch = 1'b1;
        use_rs = 1'b1;
        use_rt = 1'b1;
      end
      OP_J: begin
        jump = 1'b1;
      end
      HALT_OP: begin
        is_halt = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/decode_stage_reg.sv
// Registered decode stage: register file with write-back bypass, control
// decode, load-use bubble insertion and a valid/ready ID/EX register.
//
// Handshake: a transfer on either side happens on a rising edge where
// valid && ready are both high. in_ready never depends on in_valid; the
// ID/EX register moves only when it is empty or EX takes it (out_ready).
module decode_stage_reg
  import decode_stage_reg_pkg::*;
#(
  parameter int WORD     = WORD_DEF,
  parameter int NUM_REGS = 32,
  parameter int RA_W     = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic            flush,
  input  logic            wb_en,
  input  logic [RA_W-1:0] wb_dest,
  input  logic [WORD-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      out_alu_op,
  output logic            out_mem_r,
  output logic            out_mem_w,
  output logic            out_wb_en,
  output logic            out_branch,
  output logic            out_jump,
  output logic [RA_W-1:0] out_rs,
  output logic [RA_W-1:0] out_rt,
  output logic [RA_W-1:0] out_rd,
  output logic [WORD-1:0] out_alu_a,
  output logic [WORD-1:0] out_alu_b,
  output logic [WORD-1:0] out_st_data,
  output logic [WORD-1:0] out_imm,
  output logic [25:0]     out_jaddr,
  output logic            halted
);

  logic [WORD-1:0] regs [NUM_REGS];

  logic [RA_W-1:0] rs_f, rt_f, rd_f;
  logic [WORD-1:0] rs_val, rt_val, imm_ext, shamt_ext;

  logic [3:0] c_alu_op;
  logic c_mem_r, c_mem_w, c_wb_en, c_branch, c_jump, c_halt;
  logic c_use_rs, c_use_rt, c_a_shamt, c_b_imm, c_rd_is_rd, c_rd_is_rt, c_st_rt;

  logic [RA_W-1:0] d_rs, d_rt, d_rd;
  logic [WORD-1:0] d_a, d_b, d_st;

  logic stall, can_adv, accept;

  assign rs_f      = RA_W'(instr[25:21]);
  assign rt_f      = RA_W'(instr[20:16]);
  assign rd_f      = RA_W'(instr[15:11]);
  assign imm_ext   = {{(WORD-16){instr[15]}}, instr[15:0]};
  assign shamt_ext = {{(WORD-5){1'b0}}, instr[10:6]};

  decode_ctrl u_ctrl (
    .opcode   (instr[31:26]),
    .funct    (instr[5:0]),
    .alu_op   (c_alu_op),
    .mem_r    (c_mem_r),
    .mem_w    (c_mem_w),
    .wb_en    (c_wb_en),
    .branch   (c_branch),
    .jump     (c_jump),
    .is_halt  (c_halt),
    .use_rs   (c_use_rs),
    .use_rt   (c_use_rt),
    .a_shamt  (c_a_shamt),
    .b_imm    (c_b_imm),
    .rd_is_rd (c_rd_is_rd),
    .rd_is_rt (c_rd_is_rt),
    .st_rt    (c_st_rt)
  );

  // Register file write port; r0 is never written
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wb_en && (wb_dest != '0) && (int'(wb_dest) < NUM_REGS)) begin
      regs[wb_dest] <= wb_data;
    end
  end

  // rs read port with same-cycle write-back bypass
  always_comb begin
    rs_val = '0;
    if (rs_f != '0) begin
      if (wb_en && (wb_dest == rs_f))     rs_val = wb_data;
      else if (int'(rs_f) < NUM_REGS)     rs_val = regs[rs_f];
    end
  end

  // rt read port with same-cycle write-back bypass
  always_comb begin
    rt_val = '0;
    if (rt_f != '0) begin
      if (wb_en && (wb_dest == rt_f))     rt_val = wb_data;
      else if (int'(rt_f) < NUM_REGS)     rt_val = regs[rt_f];
    end
  end

  // Operand and register-field selection; unused sources read as 0
  always_comb begin
    d_rs = c_use_rs ? rs_f : '0;
    d_rt = c_use_rt ? rt_f : '0;
    d_rd = '0;
    if (c_rd_is_rd)      d_rd = rd_f;
    else if (c_rd_is_rt) d_rd = rt_f;
    d_a = '0;
    if (c_a_shamt)       d_a = shamt_ext;
    else if (c_use_rs)   d_a = rs_val;
    d_b = '0;
    if (c_b_imm)         d_b = imm_ext;
    else if (c_use_rt)   d_b = rt_val;
    d_st = c_st_rt ? rt_val : '0;
  end

  // A load in ID/EX whose destination feeds this instruction cannot be
  // forwarded in time, so hold the instruction one cycle behind a bubble.
  assign stall    = out_valid && out_mem_r && (out_rd != '0) &&
                    ((d_rs == out_rd) || (d_rt == out_rd));
  assign can_adv  = !out_valid || out_ready;
  assign in_ready = flush || (!halted && !stall && can_adv);
  assign accept   = in_valid && in_ready && !flush;

  // ID/EX register: flush empties it, otherwise it loads the accepted
  // instruction or a cleared bubble whenever it is free to move
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_alu_op  <= '0;
      out_mem_r   <= 1'b0;
      out_mem_w   <= 1'b0;
      out_wb_en   <= 1'b0;
      out_branch  <= 1'b0;
      out_jump    <= 1'b0;
      out_rs      <= '0;
      out_rt      <= '0;
      out_rd      <= '0;
      out_alu_a   <= '0;
      out_alu_b   <= '0;
      out_st_data <= '0;
      out_imm     <= '0;
      out_jaddr   <= '0;
    end else if (flush || can_adv) begin
      out_valid   <= accept;
      out_alu_op  <= accept ? c_alu_op     : '0;
      out_mem_r   <= accept ? c_mem_r      : 1'b0;
      out_mem_w   <= accept ? c_mem_w      : 1'b0;
      out_wb_en   <= accept ? c_wb_en      : 1'b0;
      out_branch  <= accept ? c_branch     : 1'b0;
      out_jump    <= accept ? c_jump       : 1'b0;
      out_rs      <= accept ? d_rs         : '0;
      out_rt      <= accept ? d_rt         : '0;
      out_rd      <= accept ? d_rd         : '0;
      out_alu_a   <= accept ? d_a          : '0;
      out_alu_b   <= accept ? d_b          : '0;
      out_st_data <= accept ? d_st         : '0;
      out_imm     <= accept ? imm_ext      : '0;
      out_jaddr   <= accept ? instr[25:0]  : '0;
    end
  end

  // Sticky halt flag, set on the edge the halt instruction is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   halted <= 1'b0;
    else if (accept && c_halt) halted <= 1'b1;
  end

endmodule

// File: tb/tb_decode_stage_reg.sv
// Bench for decode_stage_reg: directed scenarios followed by random traffic,
// checked against a transaction-level model of the ID/EX slot.
module tb_decode_stage_reg;

  typedef struct packed {
    logic [3:0]  alu;
    logic        mem_r, mem_w, wb, br, j;
    logic [4:0]  rs, rt, rd;
    logic [31:0] a, b, st, imm;
    logic [25:0] jaddr;
  } dec_t;

  localparam int DEC_W = $bits(dec_t);

  logic        clk, rst, in_valid, in_ready, flush, wb_en, out_ready, out_valid, halted;
  logic [31:0] instr, wb_data;
  logic [4:0]  wb_dest;
  logic [3:0]  out_alu_op;
  logic        out_mem_r, out_mem_w, out_wb_en, out_branch, out_jump;
  logic [4:0]  out_rs, out_rt, out_rd;
  logic [31:0] out_alu_a, out_alu_b, out_st_data, out_imm;
  logic [25:0] out_jaddr;

  decode_stage_reg dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .flush(flush), .wb_en(wb_en), .wb_dest(wb_dest), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_alu_op(out_alu_op),
    .out_mem_r(out_mem_r), .out_mem_w(out_mem_w), .out_wb_en(out_wb_en),
    .out_branch(out_branch), .out_jump(out_jump), .out_rs(out_rs), .out_rt(out_rt),
    .out_rd(out_rd), .out_alu_a(out_alu_a), .out_alu_b(out_alu_b),
    .out_st_data(out_st_data), .out_imm(out_imm), .out_jaddr(out_jaddr), .halted(halted)
  );

  logic [DEC_W-1:0] dut_vec;
  assign dut_vec = {out_alu_op, out_mem_r, out_mem_w, out_wb_en, out_branch, out_jump,
                    out_rs, out_rt, out_rd, out_alu_a, out_alu_b, out_st_data, out_imm, out_jaddr};

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [DEC_W-1:0] exp_q[$];
  logic [31:0] m_rf [32];
  logic m_halted;

  task automatic check(input string tag, input logic [DEC_W-1:0] got, input logic [DEC_W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] rdv(input logic [4:0] a, input logic we,
                                      input logic [4:0] wd, input logic [31:0] wdat);
    if (a == 5'd0) return 32'd0;
    if (we && wd == a) return wdat;
    return m_rf[a];
  endfunction

  function automatic dec_t exp_decode(input logic [31:0] ins, input logic we,
                                      input logic [4:0] wd, input logic [31:0] wdat);
    dec_t d;
    logic [5:0] op, fn;
    logic [4:0] rs, rt, rd;
    op = ins[31:26]; fn = ins[5:0];
    rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
    d = '0;
    d.alu   = 4'd15;
    d.imm   = {{16{ins[15]}}, ins[15:0]};
    d.jaddr = ins[25:0];
    case (op)
      6'h00: begin
        case (fn)
          6'h20, 6'h22, 6'h24, 6'h25, 6'h2a: begin
            d.alu = (fn == 6'h20) ? 4'd0 : (fn == 6'h22) ? 4'd1 : (fn == 6'h24) ? 4'd2 :
                    (fn == 6'h25) ? 4'd3 : 4'd4;
            d.wb = 1'b1; d.rs = rs; d.rt = rt; d.rd = rd;
            d.a = rdv(rs, we, wd, wdat); d.b = rdv(rt, we, wd, wdat);
          end
          6'h00, 6'h02: begin
            d.alu = (fn == 6'h00) ? 4'd5 : 4'd6;
            d.wb = 1'b1; d.rt = rt; d.rd = rd;
            d.a = 32'(ins[10:6]); d.b = rdv(rt, we, wd, wdat);
          end
          default: ;
        endcase
      end
      6'h08, 6'h23, 6'h2b: begin
        d.alu = 4'd0; d.rs = rs; d.rd = rt;
        d.a = rdv(rs, we, wd, wdat); d.b = d.imm;
        d.mem_r = (op == 6'h23); d.mem_w = (op == 6'h2b); d.wb = (op != 6'h2b);
        if (op == 6'h2b) d.st = rdv(rt, we, wd, wdat);
      end
      6'h04: begin
        d.alu = 4'd1; d.br = 1'b1; d.rs = rs; d.rt = rt;
        d.a = rdv(rs, we, wd, wdat); d.b = rdv(rt, we, wd, wdat);
      end
      6'h02: d.j = 1'b1;
      default: ;
    endcase
    return d;
  endfunction

  // ---------------- instruction encoders ----------------
  function automatic logic [31:0] r_ins(input logic [5:0] fn, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [4:0] rs, rt, rd;
    logic [5:0] fns [7];
    int k;
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h00, 6'h02};
    rs = 5'($urandom_range(0, 7)); rt = 5'($urandom_range(0, 7)); rd = 5'($urandom_range(0, 7));
    k = $urandom_range(0, 12);
    case (k)
      0, 1, 2, 3: return r_ins(fns[$urandom_range(0, 6)], rs, rt, rd, 5'($urandom_range(0, 31)));
      4:          return i_ins(6'h08, rs, rt, 16'($urandom));
      5, 6, 7:    return i_ins(6'h23, rs, rt, 16'($urandom));
      8:          return i_ins(6'h2b, rs, rt, 16'($urandom));
      9:          return i_ins(6'h04, rs, rt, 16'($urandom));
      10:         return {6'h02, 26'($urandom)};
      11:         return {6'h0c, 26'($urandom)};
      default:    return r_ins(6'h3a, rs, rt, rd, 5'd0);
    endcase
  endfunction

  // ---------------- driver: one clock cycle ----------------
  // Called at a falling edge; applies inputs, checks outputs against the
  // model, advances the model and returns at the next falling edge.
  task automatic drive_cycle(input logic iv, input logic [31:0] ins, input logic ordy,
                             input logic fl, input logic we, input logic [4:0] wd,
                             input logic [31:0] wdat);
    dec_t rec, h;
    logic m_valid, stl, adv, exp_rdy, acc;
    in_valid = iv; instr = ins; out_ready = ordy; flush = fl;
    wb_en = we; wb_dest = wd; wb_data = wdat;
    #1;
    m_valid = (exp_q.size() != 0);
    check("out_valid", out_valid, m_valid);
    check("halted", halted, m_halted);
    if (m_valid) check("idex_fields", dut_vec, exp_q[0]);
    rec = exp_decode(ins, we, wd, wdat);
    stl = 1'b0;
    if (m_valid) begin
      h = exp_q[0];
      stl = h.mem_r && (h.rd != 5'd0) && ((rec.rs == h.rd) || (rec.rt == h.rd));
    end
    adv     = !m_valid || ordy;
    exp_rdy = fl || (!m_halted && !stl && adv);
    check("in_ready", in_ready, exp_rdy);
    acc = iv && exp_rdy && !fl;
    if (fl) exp_q.delete();
    else if (adv) begin
      if (m_valid) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(rec);
    end
    if (acc && ins[31:26] == 6'h3f) m_halted = 1'b1;
    if (we && wd != 5'd0) m_rf[wd] = wdat;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_halted = 1'b0;
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
  endtask

  // Asynchronous reset pulse in the middle of the low clock phase
  task automatic pulse_reset();
    #2;
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; wb_en = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_halted", halted, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_fields", dut_vec, '0);
    model_clear();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; in_valid = 1'b0; instr = 32'd0; flush = 1'b0; out_ready = 1'b0;
    wb_en = 1'b0; wb_dest = 5'd0; wb_data = 32'd0;
    model_clear();
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_halted", halted, 1'b0);
    check("reset_in_ready", in_ready, 1'b1);
    check("reset_fields", dut_vec, '0);
    @(negedge clk);

    // Write-back bypass into add r5,r3,r0, then r3 persists, r0 bypass ignored
    drive_cycle(1, r_ins(6'h20, 5'd3, 5'd0, 5'd5, 5'd0), 1, 0, 1, 5'd3, 32'h1234);
    check("bypass_alu_a", out_alu_a, 32'h1234);
    drive_cycle(1, r_ins(6'h20, 5'd0, 5'd3, 5'd6, 5'd0), 1, 0, 1, 5'd0, 32'hdead);
    check("r0_bypass_a", out_alu_a, 32'd0);
    check("rf_persist_b", out_alu_b, 32'h1234);
    drive_cycle(1, r_ins(6'h20, 5'd0, 5'd0, 5'd6, 5'd0), 1, 0, 0, 5'd0, 32'd0);
    check("r0_write_ignored", out_alu_a, 32'd0);

    // Immediate and shift forms
    drive_cycle(1, i_ins(6'h08, 5'd1, 5'd7, 16'hfffc), 1, 0, 0, 5'd0, 32'd0);
    check("addi_imm", out_imm, 32'hfffffffc);
    check("addi_rd", out_rd, 5'd7);
    check("addi_rt", out_rt, 5'd0);
    drive_cycle(1, r_ins(6'h00, 5'd0, 5'd2, 5'd3, 5'd5), 1, 0, 0, 5'd0, 32'd0);
    check("sll_alu_a", out_alu_a, 32'd5);
    check("sll_rs", out_rs, 5'd0);
    check("sll_alu_op", out_alu_op, 4'd5);

    // Load-use: exactly one bubble, dependent issues the cycle after
    drive_cycle(1, i_ins(6'h23, 5'd1, 5'd2, 16'd0), 1, 0, 0, 5'd0, 32'd0);
    check("lu_load_valid", out_valid, 1'b1);
    drive_cycle(1, r_ins(6'h20, 5'd2, 5'd2, 5'd4, 5'd0), 1, 0, 0, 5'd0, 32'd0);
    check("lu_bubble", out_valid, 1'b0);
    drive_cycle(1, r_ins(6'h20, 5'd2, 5'd2, 5'd4, 5'd0), 1, 0, 0, 5'd0, 32'd0);
    check("lu_issue_valid", out_valid, 1'b1);
    check("lu_issue_rs", out_rs, 5'd2);

    // Back-pressure: three held cycles, nothing lost or duplicated
    drive_cycle(1, i_ins(6'h08, 5'd1, 5'd7, 16'd4), 1, 0, 0, 5'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1, r_ins(6'h25, 5'd1, 5'd2, 5'd8, 5'd0), 0, 0, 0, 5'd0, 32'd0);
      check("bp_hold_rd", out_rd, 5'd7);
    end
    drive_cycle(1, r_ins(6'h25, 5'd1, 5'd2, 5'd8, 5'd0), 1, 0, 0, 5'd0, 32'd0);
    check("bp_next_op", out_alu_op, 4'd3);
    check("bp_next_rd", out_rd, 5'd8);

    // Flush drops ID/EX and the presented instruction
    drive_cycle(1, r_ins(6'h22, 5'd1, 5'd2, 5'd9, 5'd0), 1, 0, 0, 5'd0, 32'd0);
    drive_cycle(1, r_ins(6'h24, 5'd1, 5'd2, 5'd10, 5'd0), 0, 1, 0, 5'd0, 32'd0);
    check("flush_valid", out_valid, 1'b0);
    drive_cycle(1, r_ins(6'h25, 5'd1, 5'd2, 5'd11, 5'd0), 1, 0, 0, 5'd0, 32'd0);
    check("post_flush_rd", out_rd, 5'd11);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      drive_cycle(($urandom_range(0, 9) < 8), rand_instr(), ($urandom_range(0, 9) < 7),
                  ($urandom_range(0, 19) == 0), $urandom_range(0, 1) == 1,
                  5'($urandom_range(0, 7)), $urandom);
    end
    drive_cycle(0, 32'd0, 1, 0, 0, 5'd0, 32'd0);

    // Halt: enters as NOP, then the stage refuses input
    drive_cycle(1, {6'h3f, 26'd0}, 1, 0, 0, 5'd0, 32'd0);
    check("halt_set", halted, 1'b1);
    check("halt_nop_op", out_alu_op, 4'd15);
    check("halt_nop_wb", out_wb_en, 1'b0);
    for (int i = 0; i < 3; i++) drive_cycle(1, r_ins(6'h20, 5'd1, 5'd2, 5'd3, 5'd0), 1, 0, 0, 5'd0, 32'd0);
    check("halt_in_ready", in_ready, 1'b0);
    pulse_reset();

    // Reset in the middle of a load-use stall
    drive_cycle(1, i_ins(6'h23, 5'd1, 5'd2, 16'd8), 1, 0, 0, 5'd0, 32'd0);
    in_valid = 1'b1; instr = r_ins(6'h20, 5'd2, 5'd3, 5'd4, 5'd0); out_ready = 1'b0;
    #1;
    check("stall_in_ready", in_ready, 1'b0);
    pulse_reset();
    for (int i = 0; i < 4; i++) drive_cycle(1, rand_instr(), 1, 0, 0, 5'd0, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
